// File: rtl/updown_sweep_ctrl.sv
// Direction controller for the 5-bit up/down counter: steers updown so the
// counter sweeps between programmable limits and reports reversals/round trips.
//
// state | meaning
// UP    | counter is being driven upward   (updown = 1)
// DOWN  | counter is being driven downward (updown = 0)
module updown_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] count,
    input  logic [4:0] lo_in,
    input  logic [4:0] hi_in,
    input  logic       cfg_load,
    output logic       updown,
    output logic       turn,
    output logic [7:0] sweeps,
    output logic       cfg_err
);

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    dir_t       state_q;
    dir_t       state_d;
    logic [4:0] lo_q;
    logic [4:0] hi_q;
    logic [5:0] cnt_ext;
    logic [5:0] lo_ext;
    logic [5:0] hi_ext;
    logic [5:0] hi_m1;
    logic [5:0] lo_p1;
    logic       bottom_rev;

    // 6-bit limit arithmetic keeps hi-1 / lo+1 from wrapping
    assign cnt_ext = {1'b0, count};
    assign lo_ext  = {1'b0, lo_q};
    assign hi_ext  = {1'b0, hi_q};
    assign hi_m1   = hi_ext - 6'd1;
    assign lo_p1   = lo_ext + 6'd1;

    // Reversal is decided one count early because the counter applies
    // updown on the same edge this block updates it.
    always_comb begin
        state_d = state_q;
        if (hi_q <= lo_q)
            state_d = UP;
        else if (cnt_ext > hi_ext)
            state_d = DOWN;
        else if (cnt_ext < lo_ext)
            state_d = UP;
        else if ((state_q == UP) && (cnt_ext >= hi_m1))
            state_d = DOWN;
        else if ((state_q == DOWN) && (cnt_ext <= lo_p1))
            state_d = UP;
    end

    assign bottom_rev = (state_q == DOWN) && (state_d == UP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UP;
            turn    <= 1'b0;
            sweeps  <= 8'd0;
            cfg_err <= 1'b0;
            lo_q    <= 5'd0;
            hi_q    <= 5'd31;
        end else begin
            state_q <= state_d;
            turn    <= (state_d != state_q);
            if (bottom_rev)
                sweeps <= sweeps + 8'd1;
            if (cfg_load) begin
                lo_q    <= lo_in;
                hi_q    <= hi_in;
                cfg_err <= (hi_in <= lo_in);
            end else begin
                cfg_err <= (hi_q <= lo_q);
            end
        end
    end

    assign updown = state_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl with a behavioral 5-bit up/down
// counter in the feedback loop; expected values are hand-derived per cycle.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] count;
    logic [4:0] lo_in = 5'd0;
    logic [4:0] hi_in = 5'd31;
    logic       cfg_load = 1'b0;
    logic       updown;
    logic       turn;
    logic [7:0] sweeps;
    logic       cfg_err;

    int cyc = 0;
    int base = 0;
    int errors = 0;
    int checks = 0;
    event sample_ev;

    typedef struct {
        int         cyc;
        logic [4:0] count;
        logic       updown;
        logic       turn;
        logic [7:0] sweeps;
        logic       cfg_err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    updown_sweep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .cfg_load (cfg_load),
        .updown   (updown),
        .turn     (turn),
        .sweeps   (sweeps),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    // the structural counter the controller drives
    always @(posedge clk or posedge rst) begin
        if (rst)
            count <= 5'd0;
        else if (updown)
            count <= count + 5'd1;
        else
            count <= count - 5'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int k, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s k=%0d: got %0d, expected %0d", name, k, act, exp_v);
        end
    endtask

    // monitor: pops every expectation due at this cycle and compares
    always begin
        exp_t x;
        @(negedge clk or sample_ev);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            if (x.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cycle %0d, sampled at %0d", x.tag, x.cyc, cyc);
            end else begin
                cmp({x.tag, ".count"},   x.cyc - base, int'(count),   int'(x.count));
                cmp({x.tag, ".updown"},  x.cyc - base, int'(updown),  int'(x.updown));
                cmp({x.tag, ".turn"},    x.cyc - base, int'(turn),    int'(x.turn));
                cmp({x.tag, ".sweeps"},  x.cyc - base, int'(sweeps),  int'(x.sweeps));
                cmp({x.tag, ".cfg_err"}, x.cyc - base, int'(cfg_err), int'(x.cfg_err));
            end
        end
    end

    task automatic push(input int k, input int c, input int u, input int t,
                        input int s, input int e, input string tag);
        exp_t x;
        x.cyc     = base + k;
        x.count   = 5'(c);
        x.updown  = 1'(u);
        x.turn    = 1'(t);
        x.sweeps  = 8'(s);
        x.cfg_err = 1'(e);
        x.tag     = tag;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_k(input int k);
        while (cyc < base + k) step();
    endtask

    task automatic do_reset();
        step();
        rst      = 1'b1;
        cfg_load = 1'b0;
        step();
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic load(input int lo, input int hi);
        lo_in    = 5'(lo);
        hi_in    = 5'(hi);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // L=7, H=8 from reset with the load on the first edge
    task automatic push_osc(input int kmax, input string tag);
        for (int k = 0; k <= kmax; k++) begin
            if (k < 8)
                push(k, k, 1, 0, 0, 0, tag);
            else
                push(k, (k % 2 == 0) ? 8 : 7, k % 2, 1, (k < 9) ? 0 : (k - 7) / 2, 0, tag);
        end
    endtask

    int p1_cnt[12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5};
    int p1_ud[12]  = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int p1_tn[12]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int p4_cnt[22] = '{20, 19, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30,
                       29, 28, 27, 26, 25, 26, 27};
    int p4_ud[22]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int p4_tn[22]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        // L=2, H=5 basic sweep, k0 doubles as the reset-state check
        do_reset();
        for (int i = 0; i < 12; i++)
            push(i, p1_cnt[i], p1_ud[i], p1_tn[i], (i >= 8) ? 1 : 0, 0, "lim2_5");
        load(2, 5);
        wait_k(13);

        // full range 0..31: triangle wave, one sweep per 62 cycles
        do_reset();
        for (int k = 0; k <= 130; k++)
            push(k, (k % 62 <= 31) ? (k % 62) : 62 - (k % 62), (k % 62 < 31) ? 1 : 0,
                 (k > 0 && k % 31 == 0) ? 1 : 0, k / 62, 0, "full");
        load(0, 31);
        wait_k(131);

        // H = L+1 oscillation
        do_reset();
        push_osc(40, "osc7_8");
        load(7, 8);
        wait_k(41);

        // limit change while counting down at 20
        do_reset();
        wait_k(42);
        for (int i = 0; i < 22; i++)
            push(42 + i, p4_cnt[i], p4_ud[i], p4_tn[i], (i < 2) ? 0 : ((i < 19) ? 1 : 2), 0, "reenter");
        load(25, 30);
        wait_k(64);

        // degenerate limits: free-run with wrap, then a valid load clears cfg_err
        do_reset();
        for (int k = 0; k <= 35; k++)
            push(k, k % 32, 1, 0, 0, (k >= 1) ? 1 : 0, "cfg_err");
        load(10, 10);
        wait_k(36);
        for (int k = 36; k <= 40; k++)
            push(k, k - 32, 1, 0, 0, (k == 36) ? 1 : 0, "cfg_clear");
        load(2, 20);
        wait_k(41);

        // asynchronous reset mid-cycle while DOWN with sweeps = 3
        do_reset();
        push_osc(14, "pre_rst");
        load(7, 8);
        wait_k(14);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push(cyc - base, 0, 1, 0, 0, 0, "async_rst");
        -> sample_ev;
        #1;
        do_reset();
        step();
        step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Direction controller that sits directly upstream of the 5-bit structural up/down counter. It watches the counter's `count` output and drives the counter's `updown` input so that the counter sweeps back and forth between a programmable low and high limit. It also reports direction reversals and completed round trips to the rest of the design.

## Interface
Parameters: none. Widths are fixed to the 5-bit counter.

- `clk`  in  1  rising-edge clock; the same clock as the counter.
- `rst`  in  1  asynchronous, active-high reset.
- `count`  in  5  current counter value, fed back from the counter.
- `lo_in`  in  5  requested low limit.
- `hi_in`  in  5  requested high limit.
- `cfg_load`  in  1  when high at a clock edge, `lo_in`/`hi_in` are captured.
- `updown`  out  1  registered direction to the counter: 1 = up, 0 = down.
- `turn`  out  1  registered; high for exactly one cycle in which `updown` differs from its previous value.
- `sweeps`  out  8  registered count of completed round trips; wraps 255 -> 0.
- `cfg_err`  out  1  registered; high while the captured `hi <= lo`.

## Operation
- Internal limit registers `lo_q` and `hi_q` load from `lo_in` and `hi_in` on any edge where `cfg_load` = 1.
- The new limits are used by the direction decision starting at the following edge.
- Direction logic is predictive. The counter applies `updown` at the same edge the controller updates it, so reversal is decided one count early.
- Next-`updown` rules, evaluated in priority order on the current `count`, `updown`, `lo_q` and `hi_q`:
  1. `cfg_err` condition (`hi_q <= lo_q`) -> 1. The counter then free-runs up with natural 31 -> 0 wrap.
  2. `count > hi_q` -> 0.
  3. `count < lo_q` -> 1.
  4. `updown` = 1 and `count >= hi_q - 1` -> 0.
  5. `updown` = 0 and `count <= lo_q + 1` -> 1.
  6. Otherwise, hold.
- Limit arithmetic is 6-bit unsigned, so `hi_q - 1` and `lo_q + 1` never wrap. When `hi_q > lo_q`, neither operand reaches the 5-bit boundaries.
- `turn` = (next `updown` != current `updown`). It is registered in the same edge as `updown`.
- `sweeps` increments on every edge where `updown` changes 0 -> 1 (a bottom reversal), including reversals caused by rule 3.
- The state machine is implicit in `updown`:
  - UP: `updown` = 1.
  - DOWN: `updown` = 0.
  - Transitions are given by rules 1–5. There are no other states.
- Out-of-range entry, e.g. after a limit change or after counter reset to 0 below `lo`, needs no special state. Rules 2 and 3 steer the counter back into range. One overshoot step beyond a limit is permitted during entry.

## Timing
- Reset (asynchronous, immediate):
  - `updown` = 1, `turn` = 0, `sweeps` = 0, `cfg_err` = 0.
  - `lo_q` = 0, `hi_q` = 31.
- `rst` asserted mid-sweep returns all of the above at once, independent of `clk`. The first decision after deassertion uses reset limits until a `cfg_load`.
- Latency:
  - `count` -> `updown` is 1 cycle (registered). There is no combinational path from `count` to any output.
  - `cfg_load` -> `cfg_err` is valid 1 edge later.
  - `cfg_load` -> limits affecting `updown` is 2 edges later.
- Steady-state sweep with limits L < H visits L, L+1, …, H, H-1, …, L, L+1, … Each limit value appears for exactly one cycle, with no repeats.
- H = L+1 gives a 2-value oscillation L, H, L, H.
- Full range L = 0, H = 31 sweeps 0..31..0 with no wrap.
- `cfg_load` coincident with a reversal edge: the reversal uses the old limits, and the new limits apply from the next edge.

## Test plan
- Reset, then `cfg_load` with L = 2, H = 5, counter model starting at 0:
  - Required `count`: 0,1,2,3,4,5,4,3,2,3,4,5.
  - Required `turn` pulses at the edges producing counts 5 and 2.
  - Required `sweeps` = 1 after the first return to 2.
- L = 0, H = 31: full sweep; `count` never wraps 31 -> 0 or 0 -> 31; `sweeps` increments once per 62 cycles.
- L = 7, H = 8: `count` alternates 7, 8 indefinitely; `turn` = 1 every cycle; `sweeps` increments every 2 cycles.
- While counting down at `count` = 20, load L = 25, H = 30:
  - `updown` goes to 1 within 2 edges.
  - `count` re-enters [25, 30] and then sweeps normally.
- Load L = 10, H = 10:
  - `cfg_err` = 1 and `updown` stays at 1.
  - Counter wraps 31 -> 0.
  - A later valid load clears `cfg_err`.
- Assert `rst` asynchronously between edges while DOWN with `sweeps` = 3: all outputs reach reset values before the next edge; `sweeps` = 0 and `updown` = 1.
